// File: rtl/y86_execute_pipe.sv
// Y86-64 execute stage: ALU result, condition-code register and cmov/jXX condition,
// registered behind a valid/ready handshake with flush.
module y86_execute_pipe #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned STACK_STEP = 8,
  parameter logic [2:0]  CC_RESET   = 3'b100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic             cc_inhibit,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [WIDTH-1:0] valE,
  output logic             cnd,
  output logic [2:0]       cc,
  output logic             err
);

  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STACK_STEP);

  logic             out_valid_q;
  logic [3:0]       out_icode_q;
  logic [WIDTH-1:0] vale_q, vale_d;
  logic             cnd_q, cnd_d;
  logic             err_q, err_d;
  logic [2:0]       cc_q, cc_d;
  logic             opq_ok;
  logic             accept;
  logic [WIDTH-1:0] sum, diff, t;
  logic             of;
  logic             zf, sf, ovf;

  assign in_ready = (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  assign {zf, sf, ovf} = cc_q;
  assign sum  = valB + valA;
  assign diff = valB - valA;

  always_comb begin
    vale_d = '0;
    cnd_d  = 1'b0;
    err_d  = 1'b0;
    opq_ok = 1'b0;
    t      = '0;
    of     = 1'b0;
    cc_d   = cc_q;
    case (icode)
      I_RRMOV, I_JXX: begin
        if (icode == I_RRMOV) vale_d = valA;
        case (ifun)
          4'h0:    cnd_d = 1'b1;
          4'h1:    cnd_d = (sf ^ ovf) | zf;
          4'h2:    cnd_d = sf ^ ovf;
          4'h3:    cnd_d = zf;
          4'h4:    cnd_d = !zf;
          4'h5:    cnd_d = !(sf ^ ovf);
          4'h6:    cnd_d = !(sf ^ ovf) && !zf;
          default: err_d = 1'b1;
        endcase
      end
      I_IRMOV:          vale_d = valC;
      I_RMMOV, I_MRMOV: vale_d = valB + valC;
      I_OPQ: begin
        opq_ok = 1'b1;
        case (ifun)
          4'h0: begin
            t  = sum;
            of = (valA[WIDTH-1] == valB[WIDTH-1]) && (sum[WIDTH-1] != valB[WIDTH-1]);
          end
          4'h1: begin
            t  = diff;
            of = (valA[WIDTH-1] != valB[WIDTH-1]) && (diff[WIDTH-1] != valB[WIDTH-1]);
          end
          4'h2: t = valB & valA;
          4'h3: t = valB ^ valA;
          default: begin
            opq_ok = 1'b0;
            err_d  = 1'b1;
          end
        endcase
        vale_d = t;
        if (opq_ok) cc_d = {t == '0, t[WIDTH-1], of};
      end
      I_CALL, I_PUSH: vale_d = valB - STEP_W;
      I_RET, I_POP:   vale_d = valB + STEP_W;
      default:        err_d = (icode >= 4'hC);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_icode_q <= '0;
      vale_q      <= '0;
      cnd_q       <= 1'b0;
      err_q       <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_icode_q <= icode;
        vale_q      <= vale_d;
        cnd_q       <= cnd_d;
        err_q       <= err_d;
      end else if (flush || out_ready) begin
        out_valid_q <= 1'b0;
      end
      // a flushed instruction never reaches accept, so it cannot touch CC
      if (accept && opq_ok && !cc_inhibit) cc_q <= cc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_icode = out_icode_q;
  assign valE      = vale_q;
  assign cnd       = cnd_q;
  assign err       = err_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_y86_execute_pipe.sv
// Scoreboard bench for y86_execute_pipe: directed cases then randomized traffic
// against an arithmetic reference model.
module tb_y86_execute_pipe;

  localparam int W = 64;

  typedef struct {
    logic [3:0]   icode;
    logic [W-1:0] vale;
    logic         cnd;
    logic         err;
    logic [2:0]   cc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [3:0]   icode = '0, ifun = '0;
  logic [W-1:0] valA = '0, valB = '0, valC = '0;
  logic         cc_inhibit = 1'b0, flush = 1'b0;
  logic         out_valid, out_ready = 1'b0;
  logic [3:0]   out_icode;
  logic [W-1:0] valE;
  logic         cnd, err;
  logic [2:0]   cc;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  bit   m_valid = 1'b0;
  logic [2:0] m_cc = 3'b100;

  y86_execute_pipe #(.WIDTH(W), .STACK_STEP(8), .CC_RESET(3'b100)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .cc_inhibit(cc_inhibit), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_icode(out_icode), .valE(valE), .cnd(cnd),
    .cc(cc), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit cond_of(logic [3:0] f, logic [2:0] flags);
    bit z = flags[2], s = flags[1], o = flags[0];
    bit less = s ^ o;
    case (f)
      0: return 1'b1;
      1: return less || z;
      2: return less;
      3: return z;
      4: return !z;
      5: return !less;
      6: return !less && !z;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: exact signed arithmetic in a wider integer decides overflow.
  function automatic exp_t ref_model(logic [3:0] ic, logic [3:0] fn, logic [W-1:0] a, b, c,
                                     bit inh, inout logic [2:0] flags);
    exp_t e;
    logic signed [W+1:0] sa, sb, r;
    logic [W-1:0] res;
    bit ovf;
    e.icode = ic; e.vale = '0; e.cnd = 1'b0; e.err = 1'b0;
    sa = $signed({{2{a[W-1]}}, a});
    sb = $signed({{2{b[W-1]}}, b});
    case (ic)
      4'h2, 4'h7: begin
        if (ic == 4'h2) e.vale = a;
        e.cnd = cond_of(fn, flags);
        e.err = (fn > 6);
      end
      4'h3: e.vale = c;
      4'h4, 4'h5: e.vale = b + c;
      4'h6: begin
        if (fn <= 3) begin
          ovf = 1'b0;
          case (fn)
            0: r = sb + sa;
            1: r = sb - sa;
            2: r = sb & sa;
            default: r = sb ^ sa;
          endcase
          res = r[W-1:0];
          if (fn <= 1) ovf = (r != $signed({{2{res[W-1]}}, res}));
          e.vale = res;
          if (!inh) flags = {res == '0, res[W-1], ovf};
        end else begin
          e.err = 1'b1;
        end
      end
      4'h8, 4'hA: e.vale = b - 64'd8;
      4'h9, 4'hB: e.vale = b + 64'd8;
      default: e.err = (ic >= 4'hC);
    endcase
    e.cc = flags;
    return e;
  endfunction

  // Monitor: consumes one expected entry per result transfer or flush.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && (flush || out_ready)) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        if (!flush) begin
          chk("out_icode", out_icode, e.icode);
          chk("valE", valE, e.vale);
          chk("cnd", cnd, e.cnd);
          chk("err", err, e.err);
          chk("cc_out", cc, e.cc);
        end
      end
    end
  end

  task automatic step(bit iv, logic [3:0] ic, fn, logic [W-1:0] a, b, c,
                      bit inh, bit fl, bit ordy);
    bit   exp_rdy;
    exp_t e;
    in_valid = iv; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    cc_inhibit = inh; flush = fl; out_ready = ordy;
    @(negedge clk);
    exp_rdy = (!m_valid || ordy) && !fl;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_valid);
    chk("cc", cc, m_cc);
    if (iv && exp_rdy) begin
      e = ref_model(ic, fn, a, b, c, inh, m_cc);
      q.push_back(e);
      m_valid = 1'b1;
    end else if (fl || ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    m_valid = 1'b0;
    m_cc = 3'b100;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_icode", out_icode, 0);
    chk("rst_valE", valE, 0);
    chk("rst_cnd", cnd, 0);
    chk("rst_err", err, 0);
    chk("rst_cc", cc, 3'b100);
    chk("rst_in_ready", in_ready, 1);
  endtask

  task automatic look(string nm, bit ov, logic [W-1:0] ve, bit cn, bit er, logic [2:0] ec);
    chk({nm, "_out_valid"}, out_valid, ov);
    chk({nm, "_valE"}, valE, ve);
    chk({nm, "_cnd"}, cnd, cn);
    chk({nm, "_err"}, err, er);
    chk({nm, "_cc"}, cc, ec);
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return {W{1'b1}};
      4: return 64'($urandom_range(0, 16));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [W-1:0] a, b;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // add 4+2
    step(1, 4'h6, 4'h0, 64'd4, 64'd2, 0, 0, 0, 1);
    look("add", 1, 64'd6, 0, 0, 3'b000);
    // sub to zero, then je / jne back to back
    step(1, 4'h6, 4'h1, 64'd5, 64'd5, 0, 0, 0, 1);
    look("sub", 1, 64'd0, 0, 0, 3'b100);
    step(1, 4'h7, 4'h3, 0, 0, 0, 0, 0, 1);
    look("je", 1, 64'd0, 1, 0, 3'b100);
    step(1, 4'h7, 4'h4, 0, 0, 0, 0, 0, 1);
    look("jne", 1, 64'd0, 0, 0, 3'b100);
    // signed overflow on add
    step(1, 4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 0, 0, 0, 1);
    look("ovf", 1, 64'h8000_0000_0000_0000, 0, 0, 3'b011);
    // stall: held result stays, pending irmovq taken once out_ready returns
    step(1, 4'h3, 4'h0, 0, 0, 64'h11, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'h3, 4'h0, 0, 0, 64'h22, 0, 0, 0);
      look("stall", 1, 64'h11, 0, 0, 3'b011);
    end
    step(1, 4'h3, 4'h0, 0, 0, 64'h22, 0, 0, 1);
    look("unstall", 1, 64'h22, 0, 0, 3'b011);
    // reset while stalled
    step(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    do_reset();
    // inhibited CC write, then flush with a valid input
    step(1, 4'h6, 4'h0, 64'd1, 64'd2, 0, 1, 0, 1);
    look("inhibit", 1, 64'd3, 0, 0, 3'b100);
    step(1, 4'h6, 4'h1, 64'd7, 64'd7, 0, 0, 1, 1);
    look("flush", 0, 64'd3, 0, 0, 3'b100);
    // error cases and pushq
    step(1, 4'hD, 4'h0, 64'd1, 64'd1, 64'd1, 0, 0, 1);
    look("bad_icode", 1, 64'd0, 0, 1, 3'b100);
    step(1, 4'h6, 4'h7, 64'd3, 64'd9, 0, 0, 0, 1);
    look("bad_opq", 1, 64'd0, 0, 1, 3'b100);
    step(1, 4'hA, 4'h0, 0, 64'h100, 0, 0, 0, 1);
    look("pushq", 1, 64'hF8, 0, 0, 3'b100);

    for (int i = 0; i < 3000; i++) begin
      a = pick_val();
      b = ($urandom_range(0, 7) == 0) ? a : pick_val();
      step($urandom_range(0, 9) < 8,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6)),
           a, b, pick_val(),
           $urandom_range(0, 6) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0);
      if (i == 1500) do_reset();
    end

    for (int i = 0; i < 4; i++) step(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1);
    chk("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
